// File: rtl/serial_divide_by_if.sv
// Bit-serial operand link: serial bits in, divisibility result out.
interface serial_divide_by_if #(
  parameter int unsigned WIDTH = 4
);
  logic             bit_valid;
  logic             bit_in;
  logic             frame_start;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] value;
  logic             by2;
  logic             by3;
  logic             by6;
  logic             frame_err;

  // Sender side: drives the serial stream, observes results.
  modport master (
    output bit_valid, bit_in, frame_start,
    input  busy, result_valid, value, by2, by3, by6, frame_err
  );

  // Receiver side: the divisibility detector.
  modport slave (
    input  bit_valid, bit_in, frame_start,
    output busy, result_valid, value, by2, by3, by6, frame_err
  );
endinterface

// File: rtl/serial_divide_by.sv
// Serial divisibility detector: reassembles an MSB-first frame and flags
// divisibility by 2, 3 and 6 using a running mod-6 remainder.
module serial_divide_by #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_divide_by_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [2:0]        r_q, r_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              by2_q, by2_d;
  logic              by3_q, by3_d;
  logic              by6_q, by6_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;

  logic [3:0]        r_dbl;
  logic [3:0]        r_mod;
  logic [WIDTH:0]    sh_ext;
  logic [WIDTH-1:0]  sh_load;
  logic [2:0]        r_new;
  logic [WIDTH-1:0]  sh_new;
  logic [CntW-1:0]   cnt_new;
  logic              take;

  // {r, bit} is 2*r + bit; one conditional subtract keeps it inside 0..5.
  assign r_dbl  = {r_q, bus.bit_in};
  assign r_mod  = (r_dbl >= 4'd6) ? (r_dbl - 4'd6) : r_dbl;
  // Widened concatenation keeps the shift legal when WIDTH is 1.
  assign sh_ext = {sh_q, bus.bit_in};

  // Next-state: frame start/restart, per-bit update and completion.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    value_d = value_q;
    by2_d   = by2_q;
    by3_d   = by3_q;
    by6_d   = by6_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;

    sh_load    = '0;
    sh_load[0] = bus.bit_in;
    r_new      = r_q;
    sh_new     = sh_q;
    cnt_new    = cnt_q;
    take       = 1'b0;

    if (bus.bit_valid) begin
      if (bus.frame_start) begin
        // A start while collecting aborts the partial frame.
        err_d   = (state_q == StShift);
        r_new   = {2'b00, bus.bit_in};
        sh_new  = sh_load;
        cnt_new = CntW'(1);
        take    = 1'b1;
      end else if (state_q == StShift) begin
        r_new   = r_mod[2:0];
        sh_new  = sh_ext[WIDTH-1:0];
        cnt_new = cnt_q + 1'b1;
        take    = 1'b1;
      end
    end

    if (take) begin
      r_d   = r_new;
      sh_d  = sh_new;
      cnt_d = cnt_new;
      if (cnt_new == CntW'(WIDTH)) begin
        value_d = sh_new;
        by2_d   = ~r_new[0];
        by3_d   = (r_new == 3'd0) || (r_new == 3'd3);
        by6_d   = (r_new == 3'd0);
        rv_d    = 1'b1;
        state_d = StIdle;
      end else begin
        state_d = StShift;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      value_q <= '0;
      by2_q   <= 1'b0;
      by3_q   <= 1'b0;
      by6_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      value_q <= value_d;
      by2_q   <= by2_d;
      by3_q   <= by3_d;
      by6_q   <= by6_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy         = (state_q == StShift);
  assign bus.result_valid = rv_q;
  assign bus.value        = value_q;
  assign bus.by2          = by2_q;
  assign bus.by3          = by3_q;
  assign bus.by6          = by6_q;
  assign bus.frame_err    = err_q;

endmodule

// File: doc/serial_divide_by.md
# serial_divide_by

Serial-input divisibility detector, the receiving end of the bit-serial link that carries 4-bit operands between blocks. Reassembles an MSB-first frame of `WIDTH` bits and reports whether the received value is divisible by 2, 3 and 6. Carries a running mod-6 remainder, so no full-width divider is needed. Sits downstream of the operand serializer. Its flags match the existing combinational 4-bit divisibility checker bit-for-bit for any 4-bit value.

## Interface
- `WIDTH`, default 4: frame length in bits; legal range 1..16.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `bit_valid` in 1: `bit_in` / `frame_start` are sampled this cycle.
- `bit_in` in 1: serial data, MSB first.
- `frame_start` in 1: marks the current valid bit as the first (MSB) of a frame. Ignored unless `bit_valid` = 1.
- `busy` out 1: frame in progress (state SHIFT).
- `result_valid` out 1: one-cycle pulse, new result on outputs.
- `value` out WIDTH: reassembled frame value.
- `by2` out 1: `value` mod 2 == 0.
- `by3` out 1: `value` mod 3 == 0.
- `by6` out 1: `value` mod 6 == 0.
- `frame_err` out 1: one-cycle pulse, frame aborted by an early `frame_start`.

## Operation
- **States**
  - IDLE: waiting for a frame.
  - SHIFT: collecting bits.
  - Accepted bit = `bit_valid` high on a rising edge.
- **Internal state**
  - Remainder `r` in 0..5.
  - Bit counter `cnt` in 0..WIDTH.
  - Shift register `sh` of WIDTH bits.
- **Per-bit update:** `r' = (2*r + bit_in) mod 6`, `sh' = {sh[WIDTH-2:0], bit_in}`, `cnt' = cnt + 1`. `r` must never leave 0..5.
- **IDLE**
  - Accepted bit with `frame_start` = 0: ignored, no state change.
  - Accepted bit with `frame_start` = 1: load `r = bit_in`, `sh = {0..., bit_in}`, `cnt = 1`, go to SHIFT.
- **SHIFT**
  - Accepted bit without `frame_start`: per-bit update.
  - `bit_valid` low: hold everything. Gaps of any length are legal.
- **Completion**
  - Triggered when the accepted bit makes `cnt == WIDTH`.
  - Register `value` = final `sh`.
  - `by2` = (r is 0, 2 or 4); `by3` = (r is 0 or 3); `by6` = (r == 0).
  - Pulse `result_valid`, return to IDLE.
  - With WIDTH = 1, the `frame_start` bit itself completes the frame and the block never enters SHIFT.
- **Early `frame_start` in SHIFT:** pulse `frame_err`, discard the partial frame, restart the frame with this bit exactly as in IDLE. No `result_valid` for the aborted frame.
- **Result hold:** `value`/`by*` hold until the next completion or reset.
- **Zero value:** 0 is divisible by all, so `by2` = `by3` = `by6` = 1.

## Timing
- **Reset:** `rst_n` low forces immediately (asynchronous) IDLE, `r` = 0, `cnt` = 0, `sh` = 0, `busy` = 0, `result_valid` = 0, `frame_err` = 0, `value` = 0, `by2` = `by3` = `by6` = 0.
  - Reset mid-frame discards the frame and generates no pulse.
  - Deassertion is synchronised externally. The first edge after release may accept a bit.
- **Latency:** `result_valid`, `value` and `by*` update on the same edge that accepts the last bit, so they are visible the cycle after that bit is presented.
- **Back-to-back frames:** `frame_start` may arrive on the cycle immediately after the last bit (while `result_valid` is high). Zero bubble is required; throughput is 1 bit/cycle.
- **Outputs:** all registered. `busy` rises on the edge accepting `frame_start` and falls on the completion edge (stays 0 when WIDTH = 1).
- **`frame_err`:** asserted for exactly the cycle after the offending edge.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-simulation with no clock edge. All outputs go to 0 immediately. Release, then send 0110: `value` = 6, by2/by3/by6 = 1/1/1, `result_valid` pulses once.
- **Exhaustive sweep:** WIDTH = 4, frames 0..15 back-to-back, no gaps. Per frame, `by2` = (v%2==0), `by3` = (v%3==0), `by6` = (v%6==0). Spot values:
  - 0 gives 1/1/1
  - 9 gives 0/1/0
  - 14 gives 1/0/0
  - 15 gives 0/1/0
  - Exactly 16 `result_valid` pulses over 64 cycles.
- **Gaps:** send 1100 with `bit_valid` low for 3 cycles between every bit. `result_valid` pulses once, one cycle after the 4th bit. `value` = 12, flags 1/1/1. `busy` is high throughout the gaps.
- **Abort:** send 10, then `frame_start` with bits 0011. `frame_err` pulses once. A single `result_valid` follows with `value` = 3, flags 0/1/0.
- **Idle noise:** in IDLE, send valid bits with `frame_start` = 0. No state change, `busy` = 0, `value` retains 3.
- **Mid-frame reset:** reset after 2 bits of a frame. No `result_valid`. A subsequent frame 0110 reports 6, flags 1/1/1.
